// File: rtl/reservation_station_entry_if.sv
// Bundle of issue, commit-bus snoop, execution-unit and commit-request
// signals for one reservation station entry.
//   slave  : the reservation station itself
//   master : the surrounding pipeline (issue stage, execution unit, arbiter)
interface reservation_station_entry_if #(
  parameter int WIDTH = 32,
  parameter int DST_W = 10
);
  localparam int DATA_W = 3 * WIDTH;

  // Issue packet from the operand modifier stage
  logic [3:0]        iIssueRsID;
  logic [3:0]        iSrc0Rs;
  logic [3:0]        iSrc1Rs;
  logic [DATA_W-1:0] iSrc0Data;
  logic [DATA_W-1:0] iSrc1Data;
  logic [DST_W-1:0]  iDst;
  logic [2:0]        iWE;
  logic [3:0]        iScale;

  // Modified commit bus (snooped for forwarded operands)
  logic [3:0]        iCommitRsID;
  logic [DATA_W-1:0] iCommitData;

  // Execution unit
  logic              oExeValid;
  logic              iExeReady;
  logic [DATA_W-1:0] oExeSrc0;
  logic [DATA_W-1:0] oExeSrc1;
  logic [3:0]        oExeScale;
  logic              iExeResultValid;
  logic [DATA_W-1:0] iExeResult;

  // Commit arbiter
  logic              oCommitRequest;
  logic              iCommitGrant;
  logic [3:0]        oCommitRsID;
  logic [DST_W-1:0]  oCommitDst;
  logic [2:0]        oCommitWE;
  logic [DATA_W-1:0] oCommitData;

  // Status
  logic              oBusy;
  logic              oIssueError;

  modport slave (
    input  iIssueRsID, iSrc0Rs, iSrc1Rs, iSrc0Data, iSrc1Data, iDst, iWE, iScale,
    input  iCommitRsID, iCommitData,
    input  iExeReady, iExeResultValid, iExeResult, iCommitGrant,
    output oBusy, oExeValid, oExeSrc0, oExeSrc1, oExeScale,
    output oCommitRequest, oCommitRsID, oCommitDst, oCommitWE, oCommitData,
    output oIssueError
  );

  modport master (
    output iIssueRsID, iSrc0Rs, iSrc1Rs, iSrc0Data, iSrc1Data, iDst, iWE, iScale,
    output iCommitRsID, iCommitData,
    output iExeReady, iExeResultValid, iExeResult, iCommitGrant,
    input  oBusy, oExeValid, oExeSrc0, oExeSrc1, oExeScale,
    input  oCommitRequest, oCommitRsID, oCommitDst, oCommitWE, oCommitData,
    input  oIssueError
  );
endinterface

// File: rtl/reservation_station_entry.sv
// Single-entry reservation station.
// Accepts an issue packet addressed to RS_ID, holds pending operands until
// their producer broadcasts on the commit bus, dispatches to the execution
// unit with valid/ready, then requests the commit bus for its own result.
// RS_ID must be non-zero; ID 0 means "no station" on every bus.
// Optional feature macro: RS_BACK_TO_BACK_EN -- when defined, an issue that
// arrives in the same cycle as the commit grant is accepted directly.
module reservation_station_entry #(
  parameter logic [3:0] RS_ID = 4'd1,
  parameter int         WIDTH = 32,
  parameter int         DST_W = 10
) (
  input logic                        Clock,
  input logic                        Reset,
  reservation_station_entry_if.slave rs
);

  localparam int DATA_W = 3 * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_OPS,
    S_DISPATCH,
    S_WAIT_RESULT,
    S_COMMIT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [3:0]        r_tag0;
  logic [3:0]        r_tag1;
  logic [DATA_W-1:0] r_src0;
  logic [DATA_W-1:0] r_src1;
  logic [DST_W-1:0]  r_dst;
  logic [2:0]        r_we;
  logic [3:0]        r_scale;
  logic [DATA_W-1:0] r_result;
  logic              r_issue_error;

  logic              w_snoop_valid;
  logic              w_issue_hit;
  logic              w_accept_window;
  logic              w_issue_accept;
  logic              w_issue_drop;
  logic              w_issue_fwd0;
  logic              w_issue_fwd1;
  logic [3:0]        w_issue_tag0;
  logic [3:0]        w_issue_tag1;
  logic [DATA_W-1:0] w_issue_src0;
  logic [DATA_W-1:0] w_issue_src1;
  state_t            w_issue_state;
  logic              w_fwd0;
  logic              w_fwd1;
  logic [3:0]        w_tag0_nxt;
  logic [3:0]        w_tag1_nxt;
  logic [DATA_W-1:0] w_src0_nxt;
  logic [DATA_W-1:0] w_src1_nxt;
  logic              w_busy;
  logic              w_exe_valid;
  logic              w_commit_req;
  logic [3:0]        w_commit_rsid;

  // A commit broadcast can only forward data from another station; our own
  // ID on the bus is never a producer for us.
  assign w_snoop_valid = (rs.iCommitRsID != 4'd0) && (rs.iCommitRsID != RS_ID);
  assign w_issue_hit   = (rs.iIssueRsID == RS_ID);

`ifdef RS_BACK_TO_BACK_EN
  // The entry frees up on the grant edge, so a new packet can land there.
  assign w_accept_window = (r_state == S_IDLE) ||
                           ((r_state == S_COMMIT) && rs.iCommitGrant);
`else
  assign w_accept_window = (r_state == S_IDLE);
`endif

  assign w_issue_accept = w_issue_hit && w_accept_window;
  assign w_issue_drop   = w_issue_hit && !w_accept_window;

  // Operands pending at issue can be satisfied by a same-cycle commit.
  assign w_issue_fwd0  = (rs.iSrc0Rs != 4'd0) && w_snoop_valid && (rs.iCommitRsID == rs.iSrc0Rs);
  assign w_issue_fwd1  = (rs.iSrc1Rs != 4'd0) && w_snoop_valid && (rs.iCommitRsID == rs.iSrc1Rs);
  assign w_issue_tag0  = w_issue_fwd0 ? 4'd0 : rs.iSrc0Rs;
  assign w_issue_tag1  = w_issue_fwd1 ? 4'd0 : rs.iSrc1Rs;
  assign w_issue_src0  = w_issue_fwd0 ? rs.iCommitData : rs.iSrc0Data;
  assign w_issue_src1  = w_issue_fwd1 ? rs.iCommitData : rs.iSrc1Data;
  assign w_issue_state = ((w_issue_tag0 == 4'd0) && (w_issue_tag1 == 4'd0)) ? S_DISPATCH : S_WAIT_OPS;

  // Forwarding while waiting; both tags may hit the same broadcast.
  assign w_fwd0 = (r_tag0 != 4'd0) && w_snoop_valid && (rs.iCommitRsID == r_tag0);
  assign w_fwd1 = (r_tag1 != 4'd0) && w_snoop_valid && (rs.iCommitRsID == r_tag1);

  // Next operand tags and data: issue load or commit-bus capture.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    w_tag0_nxt = r_tag0;
    w_tag1_nxt = r_tag1;
    w_src0_nxt = r_src0;
    w_src1_nxt = r_src1;
    if (w_issue_accept) begin
      w_tag0_nxt = w_issue_tag0;
      w_tag1_nxt = w_issue_tag1;
      w_src0_nxt = w_issue_src0;
      w_src1_nxt = w_issue_src1;
    end else if (r_state == S_WAIT_OPS) begin
      if (w_fwd0) begin
        w_tag0_nxt = 4'd0;
        w_src0_nxt = rs.iCommitData;
      end
      if (w_fwd1) begin
        w_tag1_nxt = 4'd0;
        w_src1_nxt = rs.iCommitData;
      end
    end
  end

  // State register.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_issue_accept) w_state_nxt = w_issue_state;
      end
      S_WAIT_OPS: begin
        if ((w_tag0_nxt == 4'd0) && (w_tag1_nxt == 4'd0)) w_state_nxt = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (rs.iExeReady) w_state_nxt = S_WAIT_RESULT;
      end
      S_WAIT_RESULT: begin
        if (rs.iExeResultValid) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        if (rs.iCommitGrant) w_state_nxt = w_issue_accept ? w_issue_state : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    w_busy        = 1'b1;
    w_exe_valid   = 1'b0;
    w_commit_req  = 1'b0;
    w_commit_rsid = 4'd0;
    unique case (r_state)
      S_IDLE:     w_busy = 1'b0;
      S_DISPATCH: w_exe_valid = 1'b1;
      S_COMMIT: begin
        w_commit_req  = 1'b1;
        w_commit_rsid = RS_ID;
      end
      default: ;
    endcase
  end

  // Operand tags and data rows.
  always_ff @(posedge Clock) begin
    // NOTE: the data registers are reset as well because they drive outputs that must read 0 after reset.
    if (!Reset) begin
      r_tag0 <= 4'd0;
      r_tag1 <= 4'd0;
      r_src0 <= '0;
      r_src1 <= '0;
    end else begin
      r_tag0 <= w_tag0_nxt;
      r_tag1 <= w_tag1_nxt;
      r_src0 <= w_src0_nxt;
      r_src1 <= w_src1_nxt;
    end
  end

  // Destination, write enables and scale captured with the issue packet.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_dst   <= '0;
      r_we    <= 3'b000;
      r_scale <= 4'd0;
    end else if (w_issue_accept) begin
      r_dst   <= rs.iDst;
      r_we    <= rs.iWE;
      r_scale <= rs.iScale;
    end
  end

  // Result capture; strobes outside WAIT_RESULT are ignored.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_result <= '0;
    end else if ((r_state == S_WAIT_RESULT) && rs.iExeResultValid) begin
      r_result <= rs.iExeResult;
    end
  end

  // Sticky error for issues that target this station while it is occupied.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_issue_error <= 1'b0;
    end else if (w_issue_drop) begin
      r_issue_error <= 1'b1;
    end
  end

  assign rs.oBusy          = w_busy;
  assign rs.oExeValid      = w_exe_valid;
  assign rs.oExeSrc0       = r_src0;
  assign rs.oExeSrc1       = r_src1;
  assign rs.oExeScale      = r_scale;
  assign rs.oCommitRequest = w_commit_req;
  assign rs.oCommitRsID    = w_commit_rsid;
  assign rs.oCommitDst     = r_dst;
  assign rs.oCommitWE      = r_we;
  assign rs.oCommitData    = r_result;
  assign rs.oIssueError    = r_issue_error;

endmodule

// File: tb/tb_reservation_station_entry.sv
// Self-checking bench for reservation_station_entry (RS_ID = 1).
// Directed scenarios followed by randomized transactions compared against a
// transaction-level model of operand forwarding and commit.
module tb_reservation_station_entry;

  localparam int         WIDTH  = 32;
  localparam int         DST_W  = 10;
  localparam int         DATA_W = 3 * WIDTH;
  localparam logic [3:0] RS_ID  = 4'd1;

  logic Clock;
  logic Reset;
  int   checks   = 0;
  int   failures = 0;

  reservation_station_entry_if #(.WIDTH(WIDTH), .DST_W(DST_W)) bus ();

  reservation_station_entry #(.RS_ID(RS_ID), .WIDTH(WIDTH), .DST_W(DST_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .rs    (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic logic [DATA_W-1:0] row(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return {x, y, z};
  endfunction

  function automatic logic [DATA_W-1:0] rand_row();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iIssueRsID      = 4'd0;
    bus.iSrc0Rs         = 4'd0;
    bus.iSrc1Rs         = 4'd0;
    bus.iSrc0Data       = '0;
    bus.iSrc1Data       = '0;
    bus.iDst            = '0;
    bus.iWE             = 3'b000;
    bus.iScale          = 4'd0;
    bus.iCommitRsID     = 4'd0;
    bus.iCommitData     = '0;
    bus.iExeReady       = 1'b0;
    bus.iExeResultValid = 1'b0;
    bus.iExeResult      = '0;
    bus.iCommitGrant    = 1'b0;
  endtask

  task automatic issue(input logic [3:0] rs0, input logic [3:0] rs1,
                       input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                       input logic [DST_W-1:0] dst, input logic [2:0] we, input logic [3:0] scale);
    bus.iIssueRsID = RS_ID;
    bus.iSrc0Rs    = rs0;
    bus.iSrc1Rs    = rs1;
    bus.iSrc0Data  = d0;
    bus.iSrc1Data  = d1;
    bus.iDst       = dst;
    bus.iWE        = we;
    bus.iScale     = scale;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
  endtask

  // From DISPATCH: handshake, result, grant -- entry ends IDLE.
  task automatic drain(input logic [DATA_W-1:0] res);
    bus.iExeReady = 1'b1;       tick(); bus.iExeReady = 1'b0;
    bus.iExeResultValid = 1'b1; bus.iExeResult = res;
    tick();                     bus.iExeResultValid = 1'b0;
    bus.iCommitGrant = 1'b1;    tick(); bus.iCommitGrant = 1'b0;
  endtask

  // Ready issue through to COMMIT with the given result.
  task automatic to_commit(input logic [DATA_W-1:0] res);
    issue(4'd0, 4'd0, row(1, 1, 1), row(2, 2, 2), 10'h001, 3'b111, 4'h1);
    tick(); bus.iIssueRsID = 4'd0;
    bus.iExeReady = 1'b1;       tick(); bus.iExeReady = 1'b0;
    bus.iExeResultValid = 1'b1; bus.iExeResult = res;
    tick();                     bus.iExeResultValid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b0;
    tick(); tick();
    checks++;
    if ({bus.oBusy, bus.oExeValid, bus.oExeSrc0, bus.oExeSrc1, bus.oExeScale, bus.oCommitRequest,
         bus.oCommitRsID, bus.oCommitDst, bus.oCommitWE, bus.oCommitData, bus.oIssueError} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%0b valid=%0b req=%0b err=%0b src0=%h data=%h, required all zero",
               bus.oBusy, bus.oExeValid, bus.oCommitRequest, bus.oIssueError, bus.oExeSrc0, bus.oCommitData);
    end
    Reset = 1'b1;
    tick();
    checks++; if (bus.oBusy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %0b want 0", bus.oBusy); end
  endtask

  task automatic test_ready_issue();
    issue(4'd0, 4'd0, row(1, 2, 3), row(4, 5, 6), 10'h155, 3'b101, 4'h9);
    tick(); bus.iIssueRsID = 4'd0;
    checks++; if (bus.oExeValid !== 1'b1) begin failures++; $display("FAIL ready_valid: got %0b want 1", bus.oExeValid); end
    checks++; if (bus.oBusy !== 1'b1) begin failures++; $display("FAIL ready_busy: got %0b want 1", bus.oBusy); end
    checks++; if (bus.oExeSrc0 !== row(1, 2, 3)) begin failures++; $display("FAIL ready_src0: got %h want %h", bus.oExeSrc0, row(1, 2, 3)); end
    checks++; if (bus.oExeSrc1 !== row(4, 5, 6)) begin failures++; $display("FAIL ready_src1: got %h want %h", bus.oExeSrc1, row(4, 5, 6)); end
    checks++; if (bus.oExeScale !== 4'h9) begin failures++; $display("FAIL ready_scale: got %h want 9", bus.oExeScale); end
    // Stray result strobe while dispatching must be ignored.
    bus.iExeResultValid = 1'b1; bus.iExeResult = row(32'hDEAD, 32'hDEAD, 32'hDEAD);
    tick(); bus.iExeResultValid = 1'b0;
    checks++; if (bus.oExeValid !== 1'b1) begin failures++; $display("FAIL stray_strobe_valid: got %0b want 1", bus.oExeValid); end
    bus.iExeReady = 1'b1;
    tick(); bus.iExeReady = 1'b0;
    checks++; if (bus.oExeValid !== 1'b0) begin failures++; $display("FAIL handshake_valid_fall: got %0b want 0", bus.oExeValid); end
    // Grant while not requesting must be ignored.
    bus.iCommitGrant = 1'b1;
    tick(); bus.iCommitGrant = 1'b0;
    checks++; if (bus.oBusy !== 1'b1 || bus.oCommitRequest !== 1'b0) begin
      failures++; $display("FAIL stray_grant: busy=%0b req=%0b want busy=1 req=0", bus.oBusy, bus.oCommitRequest);
    end
    bus.iExeResultValid = 1'b1; bus.iExeResult = row(32'h10, 32'h10, 32'h10);
    tick(); bus.iExeResultValid = 1'b0;
    checks++; if (bus.oCommitRequest !== 1'b1) begin failures++; $display("FAIL commit_req: got %0b want 1", bus.oCommitRequest); end
    checks++; if (bus.oCommitRsID !== RS_ID) begin failures++; $display("FAIL commit_rsid: got %0d want %0d", bus.oCommitRsID, RS_ID); end
    checks++; if (bus.oCommitData !== row(32'h10, 32'h10, 32'h10)) begin failures++; $display("FAIL commit_data: got %h want 10/10/10", bus.oCommitData); end
    checks++; if (bus.oCommitDst !== 10'h155 || bus.oCommitWE !== 3'b101) begin
      failures++; $display("FAIL commit_dst_we: got %h/%b want 155/101", bus.oCommitDst, bus.oCommitWE);
    end
    tick();
    checks++; if (bus.oCommitRequest !== 1'b1) begin failures++; $display("FAIL commit_hold: got %0b want 1", bus.oCommitRequest); end
    bus.iCommitGrant = 1'b1;
    tick(); bus.iCommitGrant = 1'b0;
    checks++; if (bus.oBusy !== 1'b0 || bus.oCommitRequest !== 1'b0 || bus.oCommitRsID !== 4'd0) begin
      failures++; $display("FAIL grant_release: busy=%0b req=%0b rsid=%0d want 0/0/0", bus.oBusy, bus.oCommitRequest, bus.oCommitRsID);
    end
  endtask

  task automatic test_forwarding();
    issue(4'd3, 4'd3, row(7, 7, 7), row(8, 8, 8), 10'h020, 3'b111, 4'h2);
    tick(); bus.iIssueRsID = 4'd0;
    checks++; if (bus.oExeValid !== 1'b0 || bus.oBusy !== 1'b1) begin
      failures++; $display("FAIL fwd_wait: valid=%0b busy=%0b want 0/1", bus.oExeValid, bus.oBusy);
    end
    bus.iCommitRsID = 4'd2; bus.iCommitData = row(32'hBB, 32'hBB, 32'hBB);
    tick();
    checks++; if (bus.oExeValid !== 1'b0) begin failures++; $display("FAIL fwd_wrong_id: valid got %0b want 0", bus.oExeValid); end
    bus.iCommitRsID = 4'd3; bus.iCommitData = row(32'hAA, 32'hAA, 32'hAA);
    tick(); bus.iCommitRsID = 4'd0;
    checks++; if (bus.oExeValid !== 1'b1) begin failures++; $display("FAIL fwd_valid: got %0b want 1", bus.oExeValid); end
    checks++; if (bus.oExeSrc0 !== row(32'hAA, 32'hAA, 32'hAA) || bus.oExeSrc1 !== row(32'hAA, 32'hAA, 32'hAA)) begin
      failures++; $display("FAIL fwd_operands: got %h / %h want AA rows", bus.oExeSrc0, bus.oExeSrc1);
    end
    drain(row(0, 0, 1));
  endtask

  task automatic test_self_forward();
    bus.iCommitRsID = RS_ID; bus.iCommitData = row(32'hEE, 32'hEE, 32'hEE);
    issue(RS_ID, 4'd0, row(1, 1, 1), row(2, 2, 2), 10'h000, 3'b001, 4'h0);
    tick(); bus.iIssueRsID = 4'd0;
    checks++; if (bus.oExeValid !== 1'b0) begin failures++; $display("FAIL self_fwd_issue: valid got %0b want 0", bus.oExeValid); end
    tick(); bus.iCommitRsID = 4'd0;
    checks++; if (bus.oExeValid !== 1'b0 || bus.oBusy !== 1'b1) begin
      failures++; $display("FAIL self_fwd_wait: valid=%0b busy=%0b want 0/1", bus.oExeValid, bus.oBusy);
    end
    do_reset();
  endtask

  task automatic test_same_cycle_snoop();
    bus.iCommitRsID = 4'd5; bus.iCommitData = row(32'h55, 32'h55, 32'h55);
    issue(4'd0, 4'd5, row(7, 8, 9), row(0, 0, 0), 10'h033, 3'b010, 4'h4);
    tick(); bus.iIssueRsID = 4'd0; bus.iCommitRsID = 4'd0;
    checks++; if (bus.oExeValid !== 1'b1) begin failures++; $display("FAIL snoop_valid: got %0b want 1", bus.oExeValid); end
    checks++; if (bus.oExeSrc1 !== row(32'h55, 32'h55, 32'h55) || bus.oExeSrc0 !== row(7, 8, 9)) begin
      failures++; $display("FAIL snoop_operands: got %h / %h", bus.oExeSrc0, bus.oExeSrc1);
    end
    drain(row(0, 0, 2));
  endtask

  task automatic test_backpressure();
    int hs;
    issue(4'd0, 4'd0, row(32'h11, 32'h22, 32'h33), row(32'h44, 32'h55, 32'h66), 10'h2F0, 3'b110, 4'hC);
    tick(); bus.iIssueRsID = 4'd0;
    for (int i = 0; i < 5; i++) begin
      bus.iSrc0Data = rand_row(); bus.iSrc1Data = rand_row();
      bus.iCommitRsID = 4'($urandom_range(2, 15)); bus.iCommitData = rand_row();
      tick();
      checks++;
      if (bus.oExeValid !== 1'b1 || bus.oExeSrc0 !== row(32'h11, 32'h22, 32'h33) ||
          bus.oExeSrc1 !== row(32'h44, 32'h55, 32'h66) || bus.oExeScale !== 4'hC) begin
        failures++; $display("FAIL backpressure_hold[%0d]: valid=%0b src0=%h src1=%h scale=%h", i, bus.oExeValid, bus.oExeSrc0, bus.oExeSrc1, bus.oExeScale);
      end
    end
    bus.iCommitRsID = 4'd0;
    hs = 0;
    bus.iExeReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.oExeValid === 1'b1) hs++;
      tick();
    end
    bus.iExeReady = 1'b0;
    checks++; if (hs !== 1) begin failures++; $display("FAIL backpressure_handshakes: got %0d want 1", hs); end
    checks++; if (bus.oBusy !== 1'b1 || bus.oCommitRequest !== 1'b0) begin
      failures++; $display("FAIL backpressure_wait_result: busy=%0b req=%0b want 1/0", bus.oBusy, bus.oCommitRequest);
    end
    bus.iExeResultValid = 1'b1; bus.iExeResult = row(3, 3, 3);
    tick(); bus.iExeResultValid = 1'b0;
    bus.iCommitGrant = 1'b1; tick(); bus.iCommitGrant = 1'b0;
  endtask

  task automatic test_busy_issue();
    issue(4'd0, 4'd0, row(11, 12, 13), row(14, 15, 16), 10'h0AA, 3'b011, 4'h3);
    tick(); bus.iIssueRsID = 4'd0;
    bus.iExeReady = 1'b1; tick(); bus.iExeReady = 1'b0;
    issue(4'd0, 4'd0, row(99, 99, 99), row(98, 98, 98), 10'h3FF, 3'b111, 4'hF);
    tick(); bus.iIssueRsID = 4'd0;
    checks++; if (bus.oIssueError !== 1'b1) begin failures++; $display("FAIL busy_issue_error: got %0b want 1", bus.oIssueError); end
    checks++; if (bus.oExeSrc0 !== row(11, 12, 13) || bus.oExeScale !== 4'h3 || bus.oExeValid !== 1'b0) begin
      failures++; $display("FAIL busy_issue_unchanged: src0=%h scale=%h valid=%0b", bus.oExeSrc0, bus.oExeScale, bus.oExeValid);
    end
    bus.iExeResultValid = 1'b1; bus.iExeResult = row(7, 7, 7);
    tick(); bus.iExeResultValid = 1'b0;
    checks++; if (bus.oCommitDst !== 10'h0AA || bus.oCommitWE !== 3'b011 || bus.oCommitData !== row(7, 7, 7)) begin
      failures++; $display("FAIL busy_issue_commit: dst=%h we=%b data=%h want 0aa/011/7s", bus.oCommitDst, bus.oCommitWE, bus.oCommitData);
    end
    bus.iCommitGrant = 1'b1; tick(); bus.iCommitGrant = 1'b0;
    checks++; if (bus.oIssueError !== 1'b1 || bus.oBusy !== 1'b0) begin
      failures++; $display("FAIL busy_issue_sticky: err=%0b busy=%0b want 1/0", bus.oIssueError, bus.oBusy);
    end
    do_reset();
    checks++; if (bus.oIssueError !== 1'b0) begin failures++; $display("FAIL busy_issue_reset_clear: got %0b want 0", bus.oIssueError); end
  endtask

  task automatic test_grant_cycle_issue();
    to_commit(row(5, 5, 5));
    issue(4'd0, 4'd0, row(21, 22, 23), row(24, 25, 26), 10'h111, 3'b100, 4'h6);
    bus.iCommitGrant = 1'b1;
    tick(); bus.iIssueRsID = 4'd0; bus.iCommitGrant = 1'b0;
`ifdef RS_BACK_TO_BACK_EN
    checks++; if (bus.oIssueError !== 1'b0) begin failures++; $display("FAIL b2b_error: got %0b want 0", bus.oIssueError); end
    checks++; if (bus.oExeValid !== 1'b1 || bus.oExeSrc0 !== row(21, 22, 23) || bus.oExeScale !== 4'h6) begin
      failures++; $display("FAIL b2b_accept: valid=%0b src0=%h scale=%h", bus.oExeValid, bus.oExeSrc0, bus.oExeScale);
    end
    drain(row(0, 0, 3));
`else
    checks++; if (bus.oIssueError !== 1'b1) begin failures++; $display("FAIL grant_issue_error: got %0b want 1", bus.oIssueError); end
    checks++; if (bus.oBusy !== 1'b0 || bus.oExeValid !== 1'b0) begin
      failures++; $display("FAIL grant_issue_dropped: busy=%0b valid=%0b want 0/0", bus.oBusy, bus.oExeValid);
    end
    issue(4'd0, 4'd0, row(21, 22, 23), row(24, 25, 26), 10'h111, 3'b100, 4'h6);
    tick(); bus.iIssueRsID = 4'd0;
    checks++; if (bus.oExeValid !== 1'b1 || bus.oExeSrc0 !== row(21, 22, 23)) begin
      failures++; $display("FAIL grant_issue_retry: valid=%0b src0=%h", bus.oExeValid, bus.oExeSrc0);
    end
    drain(row(0, 0, 3));
`endif
    do_reset();
  endtask

  task automatic test_reset_mid_op();
    to_commit(row(32'h77, 32'h77, 32'h77));
    checks++; if (bus.oCommitRequest !== 1'b1) begin failures++; $display("FAIL midop_in_commit: got %0b want 1", bus.oCommitRequest); end
    Reset = 1'b0;
    tick(); Reset = 1'b1;
    checks++;
    if ({bus.oBusy, bus.oExeValid, bus.oExeSrc0, bus.oExeSrc1, bus.oExeScale, bus.oCommitRequest,
         bus.oCommitRsID, bus.oCommitDst, bus.oCommitWE, bus.oCommitData, bus.oIssueError} !== '0) begin
      failures++;
      $display("FAIL midop_reset_outputs: busy=%0b req=%0b rsid=%0d dst=%h we=%b data=%h, required all zero",
               bus.oBusy, bus.oCommitRequest, bus.oCommitRsID, bus.oCommitDst, bus.oCommitWE, bus.oCommitData);
    end
    issue(4'd0, 4'd0, row(31, 32, 33), row(34, 35, 36), 10'h0F0, 3'b001, 4'h8);
    tick(); bus.iIssueRsID = 4'd0;
    checks++; if (bus.oExeValid !== 1'b1 || bus.oExeSrc1 !== row(34, 35, 36)) begin
      failures++; $display("FAIL midop_reissue: valid=%0b src1=%h", bus.oExeValid, bus.oExeSrc1);
    end
    drain(row(0, 0, 4));
    checks++; if (bus.oBusy !== 1'b0) begin failures++; $display("FAIL midop_drain: busy got %0b want 0", bus.oBusy); end
  endtask

  // Random transactions. Model: an operand with producer tag T takes the data
  // of the first commit-bus broadcast with ID T (excluding RS_ID), counting
  // from the issue cycle; dispatch is due on the cycle after the last capture.
  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [3:0]        t0, t1, pend0, pend1, b, other;
      logic [DATA_W-1:0] d0, d1, e0, e1, bd, res;
      logic [DST_W-1:0]  dst;
      logic [2:0]        we;
      logic [3:0]        scale;
      int                cyc;
      t0 = 4'($urandom_range(0, 15)); if (t0 == RS_ID || t0 > 4'd7) t0 = 4'd0;
      t1 = 4'($urandom_range(0, 15)); if (t1 == RS_ID || t1 > 4'd7) t1 = 4'd0;
      d0 = rand_row(); d1 = rand_row(); res = rand_row();
      dst = DST_W'($urandom()); we = 3'($urandom()); scale = 4'($urandom());
      e0 = d0; e1 = d1; pend0 = t0; pend1 = t1;
      issue(t0, t1, d0, d1, dst, we, scale);
      cyc = 0;
      do begin
        if (cyc >= 6 && pend0 != 4'd0)      b = pend0;
        else if (cyc >= 6 && pend1 != 4'd0) b = pend1;
        else                                b = 4'($urandom_range(0, 15));
        bd = rand_row();
        bus.iCommitRsID = b; bus.iCommitData = bd;
        if (b != 4'd0 && b != RS_ID && b == pend0) begin e0 = bd; pend0 = 4'd0; end
        if (b != 4'd0 && b != RS_ID && b == pend1) begin e1 = bd; pend1 = 4'd0; end
        tick();
        other = 4'($urandom_range(0, 15)); if (other == RS_ID) other = 4'd0;
        bus.iIssueRsID = other;
        cyc++;
        checks++;
        if (bus.oExeValid !== (pend0 == 4'd0 && pend1 == 4'd0) || bus.oBusy !== 1'b1) begin
          failures++; $display("FAIL rnd%0d_wait cyc%0d: valid=%0b busy=%0b want valid=%0b busy=1", n, cyc, bus.oExeValid, bus.oBusy, (pend0 == 4'd0 && pend1 == 4'd0));
        end
      end while ((pend0 != 4'd0 || pend1 != 4'd0) && cyc < 20);
      bus.iCommitRsID = 4'd0;
      if (pend0 != 4'd0 || pend1 != 4'd0) begin
        checks++; failures++;
        $display("FAIL rnd%0d_timeout: operands still pending after %0d cycles", n, cyc);
        do_reset();
        continue;
      end
      checks++;
      if (bus.oExeSrc0 !== e0 || bus.oExeSrc1 !== e1 || bus.oExeScale !== scale) begin
        failures++; $display("FAIL rnd%0d_operands: got %h / %h / %h want %h / %h / %h", n, bus.oExeSrc0, bus.oExeSrc1, bus.oExeScale, e0, e1, scale);
      end
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        bus.iCommitRsID = 4'($urandom_range(0, 15)); bus.iCommitData = rand_row();
        tick();
        checks++;
        if (bus.oExeValid !== 1'b1 || bus.oExeSrc0 !== e0 || bus.oExeSrc1 !== e1) begin
          failures++; $display("FAIL rnd%0d_stall: valid=%0b src0=%h src1=%h", n, bus.oExeValid, bus.oExeSrc0, bus.oExeSrc1);
        end
      end
      bus.iCommitRsID = 4'd0;
      bus.iExeReady = 1'b1; tick(); bus.iExeReady = 1'b0;
      checks++; if (bus.oExeValid !== 1'b0) begin failures++; $display("FAIL rnd%0d_handshake: valid got %0b want 0", n, bus.oExeValid); end
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
      bus.iExeResultValid = 1'b1; bus.iExeResult = res;
      tick(); bus.iExeResultValid = 1'b0; bus.iExeResult = rand_row();
      checks++;
      if (bus.oCommitRequest !== 1'b1 || bus.oCommitRsID !== RS_ID || bus.oCommitDst !== dst ||
          bus.oCommitWE !== we || bus.oCommitData !== res) begin
        failures++; $display("FAIL rnd%0d_commit: req=%0b rsid=%0d dst=%h we=%b data=%h want 1/%0d/%h/%b/%h",
                             n, bus.oCommitRequest, bus.oCommitRsID, bus.oCommitDst, bus.oCommitWE, bus.oCommitData, RS_ID, dst, we, res);
      end
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        tick();
        checks++; if (bus.oCommitRequest !== 1'b1) begin failures++; $display("FAIL rnd%0d_req_hold: got %0b want 1", n, bus.oCommitRequest); end
      end
      bus.iCommitGrant = 1'b1; tick(); bus.iCommitGrant = 1'b0;
      bus.iIssueRsID = 4'd0;
      checks++; if (bus.oBusy !== 1'b0 || bus.oCommitRequest !== 1'b0) begin
        failures++; $display("FAIL rnd%0d_release: busy=%0b req=%0b want 0/0", n, bus.oBusy, bus.oCommitRequest);
      end
    end
    checks++; if (bus.oIssueError !== 1'b0) begin failures++; $display("FAIL rnd_no_error: got %0b want 0", bus.oIssueError); end
  endtask

  initial begin
    Reset = 1'b0;
    idle_inputs();
    test_reset();
    test_ready_issue();
    test_forwarding();
    test_self_forward();
    test_same_cycle_snoop();
    test_backpressure();
    test_busy_issue();
    test_grant_cycle_issue();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reservation_station_entry.md
# reservation_station_entry

Single-entry reservation station that sits directly downstream of the operand modifier stage. It accepts a modified issue packet addressed to its station ID and holds any operand that is still pending. It snoops the modified commit bus to capture forwarded operands by producer station ID. Once both operands are ready it dispatches to its execution unit with a valid/ready handshake, then requests the commit bus to broadcast the result under its own ID.

## Interface
Parameters:
- RS_ID, 4'd1: this station's ID; must be non-zero (0 means "no station").
- WIDTH, 32: lane width; a data row is 3 lanes (X, Y, Z), 3*WIDTH bits.
- DST_W, 10: destination register address width.

Ports:
- Clock  in  1  single clock, all state on posedge.
- Reset  in  1  synchronous, active-low; sampled on posedge Clock.
- iIssueRsID  in  4  RSID field of the modified issue packet; entry targets this station when equal to RS_ID.
- iSrc0Rs, iSrc1Rs  in  4 each  source producer station; 0 = operand data valid now.
- iSrc0Data, iSrc1Data  in  3*WIDTH each  modified operand data; ignored when the matching iSrcNRs is non-zero.
- iDst  in  DST_W  destination address.
- iWE  in  3  per-lane write enable {X,Y,Z}.
- iScale  in  4  scale control field, passed to the execution unit.
- iCommitRsID  in  4  producer ID on the modified commit bus; 0 = bus idle.
- iCommitData  in  3*WIDTH  forwarded, already-modified data on the commit bus.
- oBusy  out  1  entry occupied.
- oExeValid  out  1  operands ready, dispatch pending.
- iExeReady  in  1  execution unit accepts.
- oExeSrc0, oExeSrc1  out  3*WIDTH each  operands to the execution unit.
- oExeScale  out  4  latched scale field.
- iExeResultValid  in  1  result strobe, one cycle.
- iExeResult  in  3*WIDTH  result data.
- oCommitRequest  out  1  request to the commit arbiter.
- iCommitGrant  in  1  grant, one cycle.
- oCommitRsID  out  4  RS_ID while requesting, else 0.
- oCommitDst  out  DST_W  latched iDst.
- oCommitWE  out  3  latched iWE.
- oCommitData  out  3*WIDTH  latched result.
- oIssueError  out  1  sticky; set when an issue targets this station while it is busy.

## Operation
- States: IDLE, WAIT_OPS, DISPATCH, WAIT_RESULT, COMMIT.
- IDLE:
  - An issue hit (iIssueRsID==RS_ID) latches the two Rs tags, the two data rows, iDst, iWE and iScale.
  - Goes to DISPATCH if both tags are 0, otherwise to WAIT_OPS.
- WAIT_OPS: per operand N with non-zero tag, if iCommitRsID==tagN then:
  - srcN data <= iCommitData;
  - tagN <= 0.
- Both tags may match the same commit in one cycle; both operands are then captured.
- WAIT_OPS goes to DISPATCH on the edge where the last pending tag clears.
- Commit snoop also applies in the IDLE issue cycle: if iSrcNRs is non-zero and equals iCommitRsID in that cycle, the operand is captured immediately with tag 0.
- DISPATCH:
  - oExeValid=1.
  - oExeSrc0, oExeSrc1 and oExeScale stay stable until handshake.
  - On oExeValid&iExeReady go to WAIT_RESULT.
- WAIT_RESULT: iExeResultValid latches iExeResult and goes to COMMIT. A strobe in any other state is ignored.
- COMMIT:
  - oCommitRequest=1 and oCommitRsID=RS_ID; oCommitDst, oCommitWE and oCommitData are held.
  - iCommitGrant goes to IDLE.
  - A grant while not requesting is ignored.
- Issue hit while not IDLE: packet dropped, oIssueError<=1. oIssueError clears only on Reset.
- Self-forwarding: a commit on the bus with ID == RS_ID does not match while waiting, because this station cannot be its own producer.
- oBusy=1 in every state except IDLE.

## Timing
- Reset (Reset==0 at posedge) forces IDLE from any state, including mid-operation.
  - All outputs are 0 on the following cycle: oBusy, oExeValid, oExeSrc*, oExeScale, oCommitRequest, oCommitRsID, oCommitDst, oCommitWE, oCommitData, oIssueError.
  - In-flight results are discarded.
- Issue with both operands ready: oExeValid rises 1 cycle after the issue edge.
- Pending operand: oExeValid rises 1 cycle after the matching commit edge.
- Dispatch handshake completes on the edge where oExeValid&iExeReady. oExeValid falls the next cycle.
- oCommitRequest rises 1 cycle after the iExeResultValid edge. It stays high until the grant edge and falls the next cycle.
- Minimum occupancy with zero execution latency is 4 cycles: issue, dispatch, result, commit.

## Configuration
- RS_BACK_TO_BACK_EN:
  - Defined: in COMMIT with iCommitGrant=1, a same-cycle issue hit is accepted and treated as an IDLE issue, with no oIssueError. The entry goes straight to WAIT_OPS or DISPATCH.
  - Undefined: such an issue is dropped with oIssueError<=1. A new issue is accepted only when the state is IDLE, which is at least 1 cycle after the grant.

## Test plan
- Ready issue: RS_ID=1, issue both Rs=0, src0=X/Y/Z 1/2/3. Required: oExeValid high next cycle, oExeSrc0 matches. iExeReady=1, then result 0x10 after 2 cycles. Required: oCommitRequest next cycle, oCommitRsID=1; grant gives oBusy=0 next cycle.
- Forwarding: issue with Src0Rs=3 and Src1Rs=3; commit RsID=3 with data 0xAA 2 cycles later. Required: both operands equal 0xAA, oExeValid 1 cycle after the commit. A commit with RsID=2 beforehand causes no capture.
- Same-cycle snoop: issue with Src1Rs=5 while iCommitRsID=5 and data 0x55. Required: DISPATCH next cycle, oExeSrc1=0x55.
- Backpressure: hold iExeReady=0 for 5 cycles. Required: oExeValid and operands stable throughout, then exactly one handshake.
- Busy issue: issue during WAIT_RESULT. Required: oIssueError=1, entry data unchanged. Repeat with issue on the grant cycle: oIssueError stays 0 only with RS_BACK_TO_BACK_EN defined.
- Reset mid-op: Reset=0 during COMMIT. Required: all outputs 0 next cycle, and a subsequent issue is accepted normally.
